// File: rtl/spi_pkg.sv
// Shared constants and mode helpers for the SPI slave.
package spi_pkg;

  localparam int SPI_MODE0 = 0;
  localparam int SPI_MODE1 = 1;
  localparam int SPI_MODE2 = 2;
  localparam int SPI_MODE3 = 3;

  // SCK idle level for a mode.
  function automatic logic cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  // 0: sample on leading edge, 1: sample on trailing edge.
  function automatic logic cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Host-side byte handshake of the SPI slave: RX strobe/data out, TX load strobe/data in.
interface spi_slave_if;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       i_TX_DV;
  logic [7:0] i_TX_Byte;

  modport slave  (output o_RX_DV, o_RX_Byte, input  i_TX_DV, i_TX_Byte);
  modport master (input  o_RX_DV, o_RX_Byte, output i_TX_DV, i_TX_Byte);
endinterface

// File: rtl/spi_sync.sv
// Two-flop synchronizer with a configurable reset value.
module spi_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_Clk,
  input  logic         i_Rst_L,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;

  // Plain double-register into the i_Clk domain.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI target, oversampled on i_Clk (>= 8x SCK), full duplex, MSB first.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SPI_MODE = 0
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  spi_slave_if.slave         host,
  input  logic               i_SPI_Clk,
  output wire                o_SPI_MISO,
  input  logic               i_SPI_MOSI,
  input  logic               i_SPI_CS_n
);
  localparam logic CPOL = cpol(SPI_MODE[1:0]);
  localparam logic CPHA = cpha(SPI_MODE[1:0]);

  logic       sck_s, mosi_s, csn_s;
  logic       sck_prev_q, csn_prev_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_byte_q, tx_hold_q, tx_shift_q;
  logic       rx_dv_q, miso_q, shifted_q;
  logic       sck_chg, lead_ev, trail_ev, cs_act, sample_ev, shift_ev, byte_done;

  spi_sync #(.W(1), .RST_VAL(CPOL)) u_sync_sck (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .d_i(i_SPI_Clk), .q_o(sck_s));
  spi_sync #(.W(1), .RST_VAL(1'b0)) u_sync_mosi (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .d_i(i_SPI_MOSI), .q_o(mosi_s));
  spi_sync #(.W(1), .RST_VAL(1'b1)) u_sync_csn (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .d_i(i_SPI_CS_n), .q_o(csn_s));

  // Previous samples of synchronized SCK and CS_n for edge detection.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sck_prev_q <= CPOL;
      csn_prev_q <= 1'b1;
    end else begin
      sck_prev_q <= sck_s;
      csn_prev_q <= csn_s;
    end
  end

  assign sck_chg  = sck_s ^ sck_prev_q;
  assign lead_ev  = sck_chg & (sck_prev_q == CPOL);
  assign trail_ev = sck_chg & (sck_s == CPOL);
  // Stay active for one cycle after CS_n rises so an 8th sample edge that
  // coincides with deselect still completes its byte.
  assign cs_act    = ~csn_s | ~csn_prev_q;
  assign sample_ev = cs_act & (CPHA ? trail_ev : lead_ev);
  // In CPHA=0 the MSB is presented before the first edge, so the trailing
  // edge that follows the 8th sample belongs to the finished byte: skip it.
  assign shift_ev  = cs_act & (CPHA ? lead_ev : trail_ev) & (CPHA | (bit_cnt_q != 3'd0));
  assign byte_done = sample_ev & (bit_cnt_q == 3'd7);
  assign bit_cnt_d  = bit_cnt_q + 3'd1;
  assign rx_shift_d = {rx_shift_q[6:0], mosi_s};

  // TX holding register: last load wins, kept until overwritten.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)          tx_hold_q <= 8'h00;
    else if (host.i_TX_DV) tx_hold_q <= host.i_TX_Byte;
  end

  // Bit counter, RX/TX shifters and the registered RX strobe.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_dv_q    <= 1'b0;
      tx_shift_q <= 8'h00;
      miso_q     <= 1'b0;
      shifted_q  <= 1'b0;
    end else begin
      rx_dv_q <= 1'b0;
      if (!cs_act) begin
        bit_cnt_q  <= 3'd0;
        rx_shift_q <= 8'h00;
        shifted_q  <= 1'b0;
        tx_shift_q <= tx_hold_q;
      end else begin
        if (sample_ev) begin
          rx_shift_q <= rx_shift_d;
          bit_cnt_q  <= bit_cnt_d;
          if (byte_done) begin
            rx_byte_q <= rx_shift_d;
            rx_dv_q   <= 1'b1;
            shifted_q <= 1'b0;
          end
        end
        if (shift_ev) begin
          if (CPHA) miso_q <= tx_shift_q[7];
          tx_shift_q <= {tx_shift_q[6:0], 1'b0};
          shifted_q  <= 1'b1;
        end else if (bit_cnt_q == 3'd0 && !shifted_q) begin
          tx_shift_q <= tx_hold_q;
        end
      end
    end
  end

  assign host.o_RX_DV   = rx_dv_q;
  assign host.o_RX_Byte = rx_byte_q;
  assign o_SPI_MISO     = i_SPI_CS_n ? 1'bz : (CPHA ? miso_q : tx_shift_q[7]);
endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench: mode-0 and mode-3 slaves driven by a bit-banged master at SCK = clk/8.
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sck_r  = 2'b10;   // [0] mode 0 idles low, [1] mode 3 idles high
  logic [1:0] mosi_r = 2'b00;
  logic [1:0] csn_r  = 2'b11;
  wire        miso0, miso3;
  pullup (miso0);
  pullup (miso3);

  int n_chk = 0, n_fail = 0;
  logic [7:0] q_rx0[$], q_rx3[$], q_tx[$];
  logic [7:0] mi;

  always #5 clk = ~clk;

  spi_slave_if h0();
  spi_slave_if h3();

  spi_slave #(.SPI_MODE(SPI_MODE0)) u0 (
    .i_Clk(clk), .i_Rst_L(rst_n), .host(h0),
    .i_SPI_Clk(sck_r[0]), .o_SPI_MISO(miso0), .i_SPI_MOSI(mosi_r[0]), .i_SPI_CS_n(csn_r[0]));
  spi_slave #(.SPI_MODE(SPI_MODE3)) u3 (
    .i_Clk(clk), .i_Rst_L(rst_n), .host(h3),
    .i_SPI_Clk(sck_r[1]), .o_SPI_MISO(miso3), .i_SPI_MOSI(mosi_r[1]), .i_SPI_CS_n(csn_r[1]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic miso_of(input int d);
    return (d != 0) ? miso3 : miso0;
  endfunction

  task automatic cs(input int d, input logic v);
    if (v) wclk(4);
    csn_r[d] = v;
    wclk(4);
  endtask

  task automatic load(input int d, input logic [7:0] b);
    if (d == 0) begin h0.i_TX_DV = 1'b1; h0.i_TX_Byte = b; end
    else        begin h3.i_TX_DV = 1'b1; h3.i_TX_Byte = b; end
    wclk(1);
    h0.i_TX_DV = 1'b0;
    h3.i_TX_DV = 1'b0;
  endtask

  // Master: d=0 is mode 0 (sample rising), d=1 is mode 3 (sample rising).
  task automatic xfer(input int d, input logic [7:0] mo, input int nb, output logic [7:0] rd);
    logic pol;
    pol = (d != 0);
    rd  = 8'h00;
    for (int i = 0; i < nb; i++) begin
      if (d == 0) begin
        mosi_r[d] = mo[7-i];
        wclk(4);
        rd = {rd[6:0], miso_of(d)};
        sck_r[d] = ~pol;
        wclk(4);
        sck_r[d] = pol;
      end else begin
        sck_r[d]  = ~pol;
        mosi_r[d] = mo[7-i];
        wclk(4);
        rd = {rd[6:0], miso_of(d)};
        sck_r[d] = pol;
        wclk(4);
      end
    end
    wclk(4);
  endtask

  // Byte-complete monitors: every strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (h0.o_RX_DV) begin
      if (q_rx0.size() == 0) chk("rx0_extra", 32'(h0.o_RX_DV), 32'd0);
      else                   chk("rx0_byte", 32'(h0.o_RX_Byte), 32'(q_rx0.pop_front()));
    end
    if (h3.o_RX_DV) begin
      if (q_rx3.size() == 0) chk("rx3_extra", 32'(h3.o_RX_DV), 32'd0);
      else                   chk("rx3_byte", 32'(h3.o_RX_Byte), 32'(q_rx3.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    h0.i_TX_DV = 1'b0; h0.i_TX_Byte = 8'h00;
    h3.i_TX_DV = 1'b0; h3.i_TX_Byte = 8'h00;
    wclk(3);
    chk("rst_dv",     32'(h0.o_RX_DV),   32'd0);
    chk("rst_byte",   32'(h0.o_RX_Byte), 32'h00);
    chk("rst_miso_z", 32'(miso0),        32'd1);
    rst_n = 1'b1;
    wclk(3);

    // Basic receive, holding register still at reset value.
    cs(0, 1'b0);
    q_rx0.push_back(8'hAA); q_tx.push_back(8'h00);
    xfer(0, 8'hAA, 8, mi);
    chk("t1_miso", 32'(mi), 32'(q_tx.pop_front()));
    cs(0, 1'b1);
    chk("t1_q", q_rx0.size(), 0);

    // TX load while idle goes out in the next byte.
    load(0, 8'h5A);
    cs(0, 1'b0);
    q_rx0.push_back(8'h66); q_tx.push_back(8'h5A);
    xfer(0, 8'h66, 8, mi);
    chk("t2_miso", 32'(mi), 32'(q_tx.pop_front()));
    cs(0, 1'b1);
    chk("t2_q", q_rx0.size(), 0);

    // Back-to-back bytes, holding byte retransmitted.
    cs(0, 1'b0);
    q_rx0.push_back(8'h99); q_rx0.push_back(8'h55);
    q_tx.push_back(8'h5A);  q_tx.push_back(8'h5A);
    xfer(0, 8'h99, 8, mi);
    chk("t3_miso_a", 32'(mi), 32'(q_tx.pop_front()));
    xfer(0, 8'h55, 8, mi);
    chk("t3_miso_b", 32'(mi), 32'(q_tx.pop_front()));
    cs(0, 1'b1);
    chk("t3_q", q_rx0.size(), 0);

    // Partial byte aborted by deselect, then a fresh byte.
    cs(0, 1'b0);
    xfer(0, 8'hF0, 5, mi);
    cs(0, 1'b1);
    cs(0, 1'b0);
    q_rx0.push_back(8'h77); q_tx.push_back(8'h5A);
    xfer(0, 8'h77, 8, mi);
    chk("t4_miso", 32'(mi), 32'(q_tx.pop_front()));
    cs(0, 1'b1);
    chk("t4_q", q_rx0.size(), 0);

    // Mid-byte TX load lands in the following byte.
    cs(0, 1'b0);
    q_rx0.push_back(8'h12); q_rx0.push_back(8'h34);
    q_tx.push_back(8'h5A);  q_tx.push_back(8'h3E);
    fork
      xfer(0, 8'h12, 8, mi);
      begin wclk(20); load(0, 8'h3E); end
    join
    chk("t5_miso_a", 32'(mi), 32'(q_tx.pop_front()));
    xfer(0, 8'h34, 8, mi);
    chk("t5_miso_b", 32'(mi), 32'(q_tx.pop_front()));
    cs(0, 1'b1);
    chk("t5_q", q_rx0.size(), 0);
    chk("t5_miso_z", 32'(miso0), 32'd1);
    cs(0, 1'b0);
    chk("t5_miso_drv", 32'(miso0), 32'd0);   // 0x3E MSB driven while selected

    // Reset in the middle of a byte.
    xfer(0, 8'hC5, 4, mi);
    rst_n = 1'b0;
    wclk(2);
    chk("t6_rst_dv",   32'(h0.o_RX_DV),   32'd0);
    chk("t6_rst_byte", 32'(h0.o_RX_Byte), 32'h00);
    rst_n = 1'b1;
    wclk(2);
    cs(0, 1'b1);
    cs(0, 1'b0);
    q_rx0.push_back(8'h33); q_tx.push_back(8'h00);
    xfer(0, 8'h33, 8, mi);
    chk("t6_miso", 32'(mi), 32'(q_tx.pop_front()));
    cs(0, 1'b1);
    chk("t6_q", q_rx0.size(), 0);

    // Mode 3 slave.
    load(1, 8'hC3);
    cs(1, 1'b0);
    q_rx3.push_back(8'h3C); q_tx.push_back(8'hC3);
    xfer(1, 8'h3C, 8, mi);
    chk("t7_miso", 32'(mi), 32'(q_tx.pop_front()));
    cs(1, 1'b1);
    chk("t7_q", q_rx3.size(), 0);
    chk("t7_miso_z", 32'(miso3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
